ps2_scan_fifo: RTL and testbench
================================

// Module: ps2_scan_fifo
// PURPOSE
//  PS/2 keyboard front end: deserialises raw ps2Clk/ps2Data frames, checks them, and queues scancodes in a small FIFO.
//  The FIFO is read by the Processor over the memory bus (SoC decode at 7F1x).
//  Sits between the keyboard pins and the CPU data mux, next to Ps2Decoder.
//  Lets software read every make/break code without loss while the CPU is busy.
// PARAMETERS
//  DEPTH_LOG2  3     FIFO depth = 2**DEPTH_LOG2 entries (8)
//  FILTER      4     consecutive equal clk samples required to accept a ps2Clk level change
//  TIMEOUT     4096  clk cycles with no ps2Clk falling edge before a partial frame is aborted
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  reset       in   1  asynchronous, active-low reset
//  ps2Clk      in   1  raw PS/2 clock pin, asynchronous
//  ps2Data     in   1  raw PS/2 data pin, asynchronous
//  strobe      in   1  bus access, one cycle per access, pre-qualified by SoC address decode
//  write       in   1  1 = write access, 0 = read access
//  addr        in   2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 COUNT
//  dataIn      in   8  write data
//  dataOut     out  8  read data, combinational from addr
//  irq         out  1  interrupt request = irqEn & ~empty
// BEHAVIOUR
//  Reset (async, reset==0)
//   - State IDLE; pointers, count, flags, irqEn and timeout all 0.
//   - Outputs: irq=0; dataOut = 0x00 (addr 0/2/3) or 0x01 (addr 1).
//  Input conditioning
//   - ps2Clk and ps2Data each pass a 2-flop synchroniser.
//   - Filtered clock changes only after FILTER equal synchronised samples.
//   - A falling edge of the filtered clock samples synchronised ps2Data. This is the bit event.
//  Frame FSM (bits arrive LSB first)
//   - IDLE: bit event with data=0 -> DATA, bitCnt=0. Data=1 is ignored.
//   - DATA: shift data in; after the 8th bit -> PARITY.
//   - PARITY: latch bit -> STOP.
//   - STOP: on the bit event, accept the frame if stop==1 and the 9 bits (data+parity) have odd parity.
//     Bad frame: discard and set frameErr. In both cases return to IDLE.
//   - Timeout counter clears on every bit event and counts in non-IDLE states.
//     Reaching TIMEOUT: -> IDLE, set frameErr, discard the partial frame.
//  FIFO
//   - Accepted frame is pushed at the STOP bit event.
//   - Push while full: byte dropped, overflow set, FIFO contents unchanged.
//   - Pop: edge with strobe & ~write & addr==0 & ~empty. Read pointer advances; dataOut showed the head byte before the edge.
//   - Read of DATA while empty returns 0x00 with no pointer change.
//   - Push and pop in the same cycle: both happen and count is unchanged. This includes the full case, where the push is accepted.
//   - Pointers wrap modulo depth. count is DEPTH_LOG2+1 bits wide, range 0..depth.
//  Registers
//   - DATA (0): read returns the head byte; writes are ignored.
//   - STATUS (1): read {4'b0, busy, overflow, frameErr, empty}; busy = FSM not IDLE.
//     Write: 1s in bits[2:1] clear overflow/frameErr (W1C). A set event in the same cycle wins over the clear.
//   - CONTROL (2): read {6'b0, irqEn, 1'b0}.
//     Write: bit0=1 flushes the FIFO (pointers and count to 0, frame FSM untouched); bit1 -> irqEn.
//     Flush and push in the same cycle: flush wins and the byte is lost.
//   - COUNT (3): read zero-extended count.
//  Latency
//   - Byte visible in DATA and irq high on the cycle after the STOP-bit event edge.
// TESTING
//  1 Frame 0x1C (data 00111000 LSB-first, parity 0, stop 1), 20us PS/2 bit period
//    -> COUNT=1, STATUS=0x00, DATA=0x1C; after the pop STATUS=0x01.
//  2 0x1C sent with parity 1 -> no push, STATUS=0x03; write STATUS 0x02 -> STATUS=0x01.
//  3 Nine frames 0x01..0x09, no reads -> COUNT=8, overflow=1; eight pops return 0x01..0x08 in order, then DATA=0x00.
//  4 FIFO full, pop on the same cycle as the 9th frame's STOP event -> COUNT stays 8, overflow=0, last entry is 0x09.
//  5 Stop ps2Clk after 4 bits -> busy=1 until TIMEOUT cycles, then busy=0, frameErr=1; the next good frame is received correctly.
//  6 Assert reset mid-frame and during a glitch (<FILTER-cycle pulse) on ps2Clk
//    -> all outputs at reset values; the glitch produces no bit event; irqEn=1 with one byte queued gives irq=1.

Source files
------------

// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard front end: syncs and filters ps2Clk/ps2Data, deframes scancodes, queues them in a FIFO.
// Latency: a byte is readable (and irq can rise) the cycle after the edge that samples its STOP bit.
// Backpressure: none toward the keyboard; a frame arriving while the FIFO is full is dropped and flags overflow.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   ps2Clk, ps2Data     raw asynchronous PS/2 pins
//   strobe, write, addr one-cycle bus access; addr 0 DATA, 1 STATUS, 2 CONTROL, 3 COUNT
//   dataIn / dataOut    bus write data / combinational read data
//   irq                 irqEn & FIFO not empty
module ps2_scan_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int FILTER     = 4,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  input  logic       strobe,
  input  logic       write,
  input  logic [1:0] addr,
  input  logic [7:0] dataIn,
  output logic [7:0] dataOut,
  output logic       irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int FW    = $clog2(FILTER + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} stateT;

  // ---------------- input conditioning ----------------
  // Sync flops reset to 1 (PS/2 idle level) so reset release never fakes a falling edge.
  logic [1:0]    clkSync, dataSync;
  logic          filtClk;
  logic [FW-1:0] filtCnt;
  logic          filtChange, bitEvent, bitData;

  // The filtered level flips on the FILTER-th consecutive differing sample.
  assign filtChange = (clkSync[1] != filtClk) && (filtCnt == FW'(FILTER - 1));
  assign bitEvent   = filtChange & filtClk;
  assign bitData    = dataSync[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clkSync  <= 2'b11;
      dataSync <= 2'b11;
      filtClk  <= 1'b1;
      filtCnt  <= '0;
    end else begin
      clkSync  <= {clkSync[0], ps2Clk};
      dataSync <= {dataSync[0], ps2Data};
      if (clkSync[1] == filtClk) begin
        filtCnt <= '0;
      end else if (filtChange) begin
        filtClk <= clkSync[1];
        filtCnt <= '0;
      end else begin
        filtCnt <= filtCnt + FW'(1);
      end
    end
  end

  // ---------------- frame FSM ----------------
  stateT         state;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic          parityBit;
  logic [TW-1:0] toCnt;
  logic          frameOk, stopEvent, pushReq, timedOut, frameErrSet;

  // Good frame: stop bit high and data+parity carry an odd number of ones.
  assign frameOk     = bitData & (^{shiftReg, parityBit});
  assign stopEvent   = bitEvent & (state == STOP);
  assign pushReq     = stopEvent & frameOk;
  assign timedOut    = (state != IDLE) & ~bitEvent & (toCnt == TW'(TIMEOUT - 1));
  assign frameErrSet = (stopEvent & ~frameOk) | timedOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bitCnt    <= '0;
      shiftReg  <= '0;
      parityBit <= 1'b0;
      toCnt     <= '0;
    end else if (bitEvent) begin
      toCnt <= '0;
      case (state)
        IDLE: begin
          if (!bitData) begin
            state  <= DATA;
            bitCnt <= '0;
          end
        end
        DATA: begin
          shiftReg <= {bitData, shiftReg[7:1]};
          if (bitCnt == 3'd7) state <= PARITY;
          else                bitCnt <= bitCnt + 3'd1;
        end
        PARITY: begin
          parityBit <= bitData;
          state     <= STOP;
        end
        STOP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end else if (state == IDLE) begin
      toCnt <= '0;
    end else if (timedOut) begin
      state <= IDLE;
      toCnt <= '0;
    end else begin
      toCnt <= toCnt + TW'(1);
    end
  end

  // ---------------- FIFO and registers ----------------
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [CW-1:0]         count;
  logic                  overflow, frameErr, irqEn;
  logic                  full, empty, pop, flush, doPush, statusWr, ctrlWr;
  logic                  unusedBits;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop      = strobe & ~write & (addr == 2'd0) & ~empty;
  assign statusWr = strobe & write & (addr == 2'd1);
  assign ctrlWr   = strobe & write & (addr == 2'd2);
  assign flush    = ctrlWr & dataIn[0];
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign doPush   = pushReq & (~full | pop) & ~flush;
  assign unusedBits = ^dataIn[7:3];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= shiftReg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      frameErr <= 1'b0;
      irqEn    <= 1'b0;
    end else begin
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + 1'b1;
        if (pop)    rdPtr <= rdPtr + 1'b1;
        count <= count + CW'(doPush) - CW'(pop);
      end
      // Set events take priority over a W1C clear in the same cycle.
      overflow <= (pushReq & full & ~pop & ~flush) | (overflow & ~(statusWr & dataIn[2]));
      frameErr <= frameErrSet | (frameErr & ~(statusWr & dataIn[1]));
      if (ctrlWr) irqEn <= dataIn[1];
    end
  end

  always_comb begin
    dataOut = 8'h00;
    case (addr)
      2'd0:    dataOut = empty ? 8'h00 : mem[rdPtr];
      2'd1:    dataOut = {4'b0, (state != IDLE), overflow, frameErr, empty};
      2'd2:    dataOut = {6'b0, irqEn, 1'b0};
      default: dataOut = 8'(count);
    endcase
  end

  assign irq = irqEn & ~empty;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Directed bench for ps2_scan_fifo: each task drives one scenario and checks its own results.
module tb_ps2_scan_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2Clk;
  logic       ps2Data;
  logic       strobe;
  logic       write;
  logic [1:0] addr;
  logic [7:0] dataIn;
  logic [7:0] dataOut;
  logic       irq;

  int total = 0;
  int bad   = 0;

  // 100 ns clock: a 20 us PS/2 bit period is 200 clk cycles.
  always #50 clk = ~clk;

  ps2_scan_fifo dut (
    .clk(clk), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .strobe(strobe), .write(write), .addr(addr), .dataIn(dataIn),
    .dataOut(dataOut), .irq(irq)
  );

  task automatic sendBit(input logic b, input int half);
    @(negedge clk);
    ps2Data = b;
    repeat (half) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic badPar, input int half);
    sendBit(1'b0, half);
    for (int i = 0; i < 8; i++) sendBit(d[i], half);
    sendBit((~^d) ^ badPar, half);
    sendBit(1'b1, half);
    repeat (10) @(negedge clk);
  endtask

  task automatic busRead(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    strobe = 1'b1; write = 1'b0; addr = a;
    #5 d = dataOut;
    @(posedge clk);
    #1 strobe = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    strobe = 1'b1; write = 1'b1; addr = a; dataIn = v;
    @(posedge clk);
    #1 strobe = 1'b0; write = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] expv;
    reset = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1;
    strobe = 1'b0; write = 1'b0; addr = 2'd0; dataIn = 8'h00;
    #300;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      expv = (a == 1) ? 8'h01 : 8'h00;
      total++;
      if (dataOut !== expv) begin
        bad++; $display("FAIL reset_dataOut addr=%0d got=%h want=%h", a, dataOut, expv);
      end
    end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", irq); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic [7:0] v;
    sendFrame(8'h1C, 1'b0, 100);
    busRead(2'd3, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t1_count got=%h want=01", v); end
    busRead(2'd1, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL t1_status got=%h want=00", v); end
    busRead(2'd0, v);
    total++; if (v !== 8'h1C) begin bad++; $display("FAIL t1_data got=%h want=1C", v); end
    busRead(2'd1, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t1_status_after_pop got=%h want=01", v); end
  endtask

  task automatic test_parity_error();
    logic [7:0] v;
    sendFrame(8'h1C, 1'b1, 20);
    busRead(2'd1, v);
    total++; if (v !== 8'h03) begin bad++; $display("FAIL t2_status_err got=%h want=03", v); end
    busWrite(2'd1, 8'h02);
    busRead(2'd1, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t2_status_clr got=%h want=01", v); end
  endtask

  task automatic test_overflow();
    logic [7:0] v;
    for (int i = 1; i <= 9; i++) sendFrame(8'(i), 1'b0, 20);
    busRead(2'd3, v);
    total++; if (v !== 8'h08) begin bad++; $display("FAIL t3_count got=%h want=08", v); end
    busRead(2'd1, v);
    total++; if (v !== 8'h04) begin bad++; $display("FAIL t3_status got=%h want=04", v); end
    for (int i = 1; i <= 8; i++) begin
      busRead(2'd0, v);
      total++;
      if (v !== 8'(i)) begin bad++; $display("FAIL t3_pop%0d got=%h want=%h", i, v, 8'(i)); end
    end
    busRead(2'd0, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL t3_empty_data got=%h want=00", v); end
    busRead(2'd3, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL t3_count_empty got=%h want=00", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [7:0] d;
    busWrite(2'd1, 8'h04);
    busRead(2'd1, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t4_ovf_clr got=%h want=01", v); end
    for (int i = 1; i <= 8; i++) sendFrame(8'(i), 1'b0, 20);
    busRead(2'd3, v);
    total++; if (v !== 8'h08) begin bad++; $display("FAIL t4_full_count got=%h want=08", v); end
    // 9th frame, with a pop lined up on the STOP bit event edge
    d = 8'h09;
    sendBit(1'b0, 20);
    for (int i = 0; i < 8; i++) sendBit(d[i], 20);
    sendBit(~^d, 20);
    @(negedge clk);
    ps2Data = 1'b1;
    repeat (20) @(negedge clk);
    ps2Clk = 1'b0;
    // two sync stages plus four filter samples: the event edge is the 6th posedge
    repeat (5) @(posedge clk);
    @(negedge clk);
    strobe = 1'b1; write = 1'b0; addr = 2'd0;
    #5 v = dataOut;
    @(posedge clk);
    #1 strobe = 1'b0;
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t4_pop_head got=%h want=01", v); end
    repeat (20) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
    busRead(2'd3, v);
    total++; if (v !== 8'h08) begin bad++; $display("FAIL t4_count got=%h want=08", v); end
    busRead(2'd1, v);
    total++; if (v !== 8'h00) begin bad++; $display("FAIL t4_status got=%h want=00", v); end
    for (int i = 2; i <= 9; i++) begin
      busRead(2'd0, v);
      total++;
      if (v !== 8'(i)) begin bad++; $display("FAIL t4_pop%0d got=%h want=%h", i, v, 8'(i)); end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] v;
    sendBit(1'b0, 20);
    sendBit(1'b1, 20);
    sendBit(1'b0, 20);
    sendBit(1'b1, 20);
    repeat (4000) @(negedge clk);
    busRead(2'd1, v);
    total++; if (v !== 8'h09) begin bad++; $display("FAIL t5_busy got=%h want=09", v); end
    repeat (200) @(negedge clk);
    busRead(2'd1, v);
    total++; if (v !== 8'h03) begin bad++; $display("FAIL t5_timeout got=%h want=03", v); end
    busWrite(2'd1, 8'h02);
    sendFrame(8'h5A, 1'b0, 20);
    busRead(2'd0, v);
    total++; if (v !== 8'h5A) begin bad++; $display("FAIL t5_next_frame got=%h want=5A", v); end
    busRead(2'd1, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t5_status_end got=%h want=01", v); end
  endtask

  task automatic test_reset_glitch();
    logic [7:0] v;
    logic [7:0] expv;
    busWrite(2'd2, 8'h02);
    sendFrame(8'h33, 1'b0, 20);
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL t6_irq_before got=%b want=1", irq); end
    // partial frame, then reset with a short ps2Clk pulse while held in reset
    sendBit(1'b0, 20);
    sendBit(1'b1, 20);
    sendBit(1'b0, 20);
    @(negedge clk);
    reset = 1'b0;
    ps2Clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2Clk = 1'b1;
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      expv = (a == 1) ? 8'h01 : 8'h00;
      total++;
      if (dataOut !== expv) begin
        bad++; $display("FAIL t6_reset_dataOut addr=%0d got=%h want=%h", a, dataOut, expv);
      end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL t6_reset_irq got=%b want=0", irq); end
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    // two-sample low pulse with data low: would start a frame if it became a bit event
    ps2Data = 1'b0;
    ps2Clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (10) @(negedge clk);
    ps2Data = 1'b1;
    busRead(2'd1, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t6_glitch_status got=%h want=01", v); end
    busWrite(2'd2, 8'h02);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL t6_irq_empty got=%b want=0", irq); end
    sendFrame(8'hA5, 1'b0, 20);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL t6_irq_one got=%b want=1", irq); end
    busRead(2'd3, v);
    total++; if (v !== 8'h01) begin bad++; $display("FAIL t6_count got=%h want=01", v); end
    busRead(2'd0, v);
    total++; if (v !== 8'hA5) begin bad++; $display("FAIL t6_data got=%h want=A5", v); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_overflow();
    test_back_to_back();
    test_timeout();
    test_reset_glitch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
